utlb_trans: RTL and testbench

Parametrised address-translation front end with a private fully associative micro-TLB (uTLB), one per pipeline access port (fetch or load/store). Resolves direct-address and DMW-mapped accesses locally and serves paged hits in one cycle. On a miss it runs a refill handshake against one search port of the shared TLB. This lets fetch and memory stages translate without holding the shared TLB search ports every cycle.

---
 rtl/utlb_trans_if.sv | 62 ++++++
 rtl/utlb_trans.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_utlb_trans.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/utlb_trans_if.sv
// ---------------------------------------------------------------------------
// utlb_trans_if
//   Bundle of every non-clock signal of one translation port:
//   - request / response handshake with the pipeline stage
//   - CSR state the translation depends on (CRMD mode bits, PLV, ASID, DMWs)
//   - flush pulse from TLB-maintenance instructions / ASID writes
//   - refill search port towards the shared TLB
//   Modports:
//     master : the environment (pipeline stage, CSR file, shared TLB)
//     slave  : the utlb_trans block
// ---------------------------------------------------------------------------
interface utlb_trans_if;
  // pipeline request / response
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_store;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic [1:0]  resp_mat;
  logic [2:0]  resp_exc;
  // CSR state
  logic        csr_da;
  logic        csr_pg;
  logic [1:0]  csr_datm;
  logic [1:0]  csr_plv;
  logic [9:0]  csr_asid;
  logic [31:0] csr_dmw0;
  logic [31:0] csr_dmw1;
  logic        flush;
  // shared-TLB refill search port
  logic        rf_req_valid;
  logic        rf_req_ready;
  logic [19:0] rf_req_vpn;
  logic        rf_resp_valid;
  logic        rf_resp_found;
  logic        rf_resp_v;
  logic        rf_resp_d;
  logic        rf_resp_g;
  logic [5:0]  rf_resp_ps;
  logic [19:0] rf_resp_ppn;
  logic [1:0]  rf_resp_mat;
  logic [1:0]  rf_resp_plv;

  modport master (
    output req_valid, req_vaddr, req_store,
    output csr_da, csr_pg, csr_datm, csr_plv, csr_asid, csr_dmw0, csr_dmw1, flush,
    output rf_req_ready, rf_resp_valid, rf_resp_found, rf_resp_v, rf_resp_d,
    output rf_resp_g, rf_resp_ps, rf_resp_ppn, rf_resp_mat, rf_resp_plv,
    input  req_ready, resp_valid, resp_paddr, resp_mat, resp_exc,
    input  rf_req_valid, rf_req_vpn
  );

  modport slave (
    input  req_valid, req_vaddr, req_store,
    input  csr_da, csr_pg, csr_datm, csr_plv, csr_asid, csr_dmw0, csr_dmw1, flush,
    input  rf_req_ready, rf_resp_valid, rf_resp_found, rf_resp_v, rf_resp_d,
    input  rf_resp_g, rf_resp_ps, rf_resp_ppn, rf_resp_mat, rf_resp_plv,
    output req_ready, resp_valid, resp_paddr, resp_mat, resp_exc,
    output rf_req_valid, rf_req_vpn
  );
endinterface

// File: rtl/utlb_trans.sv
// ---------------------------------------------------------------------------
// utlb_trans
//   Address-translation front end for one pipeline access port. Direct-address
//   and DMW-mapped accesses are resolved locally; paged accesses look up a
//   private fully associative micro-TLB and, on a miss, run one search on the
//   shared TLB through the refill port, then install the result.
//
//   Parameters : NENTRY (uTLB entries, power of two 2..16), IDXW (index width)
//   Ports      : clk, resetn (async active-low), bus (utlb_trans_if.slave:
//                request/response, CSR state, flush, refill search port)
//   Option     : `define UTLB_HUGE_PAGE_EN to let the uTLB hold 2 MiB pages;
//                without it, ps=21 results are returned but never installed.
//
//   Response latency: hit/DA/DMW one cycle after acceptance; a miss responds
//   one cycle after the refill result arrives. All outputs are registered
//   except req_ready, which drops combinationally while flush is high.
// ---------------------------------------------------------------------------
module utlb_trans #(
  parameter int NENTRY = 4,
  parameter int IDXW   = $clog2(NENTRY)
) (
  input logic         clk,
  input logic         resetn,
  utlb_trans_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RF_REQ, S_RF_WAIT, S_RESP} state_e;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_TLBR = 3'd1;
  localparam logic [2:0] EXC_PI   = 3'd2;
  localparam logic [2:0] EXC_PPI  = 3'd3;
  localparam logic [2:0] EXC_PME  = 3'd4;

`ifdef UTLB_HUGE_PAGE_EN
  localparam bit HUGE_EN = 1'b1;
`else
  localparam bit HUGE_EN = 1'b0;
`endif

  // Privilege check shared by uTLB hits and refill results.
  function automatic logic [2:0] perm_exc(input logic [1:0] cur_plv, input logic [1:0] pg_plv,
                                          input logic store, input logic dirty);
    if (cur_plv > pg_plv) return EXC_PPI;
    if (store && !dirty)  return EXC_PME;
    return EXC_NONE;
  endfunction

  // A DMW window only serves PLV0 and PLV3; PLV1/2 never hit a window.
  function automatic logic dmw_hit(input logic [31:0] dmw, input logic [31:0] va,
                                   input logic [1:0] plv);
    return (va[31:29] == dmw[31:29]) &&
           (((plv == 2'd0) && dmw[0]) || ((plv == 2'd3) && dmw[3]));
  endfunction

  // ---------------------------------------------------------------- state
  state_e              r_state;
  logic                r_resp_valid;
  logic [31:0]         r_resp_paddr;
  logic [1:0]          r_resp_mat;
  logic [2:0]          r_resp_exc;
  logic                r_rf_req_valid;
  logic [19:0]         r_rf_req_vpn;
  logic [31:0]         r_vaddr;      // vaddr of the access being refilled
  logic                r_store;
  logic                r_noinst;     // flush seen since the miss was accepted

  logic [NENTRY-1:0]   r_valid;
  logic [IDXW-1:0]     r_rr;
  logic [19:0]         r_vpn  [NENTRY];
  logic [9:0]          r_asid [NENTRY];
  logic                r_g    [NENTRY];
  logic [19:0]         r_ppn  [NENTRY];
  logic                r_d    [NENTRY];
  logic [1:0]          r_mat  [NENTRY];
  logic [1:0]          r_plv  [NENTRY];
`ifdef UTLB_HUGE_PAGE_EN
  logic                r_huge [NENTRY];
`endif

  // ---------------------------------------------------------------- lookup
  logic [19:0]       w_req_vpn;
  logic [NENTRY-1:0] w_match;
  logic              w_hit;
  logic [IDXW-1:0]   w_hit_idx;
  logic              w_hit_huge;

  assign w_req_vpn = bus.req_vaddr[31:12];

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NENTRY; i++) begin
`ifdef UTLB_HUGE_PAGE_EN
      w_match[i] = r_valid[i] &&
                   (r_huge[i] ? (r_vpn[i][19:9] == w_req_vpn[19:9]) : (r_vpn[i] == w_req_vpn)) &&
                   (r_g[i] || (r_asid[i] == bus.csr_asid));
`else
      w_match[i] = r_valid[i] && (r_vpn[i] == w_req_vpn) &&
                   (r_g[i] || (r_asid[i] == bus.csr_asid));
`endif
    end
  end

  // Lowest matching index wins (descending scan, last write sticks).
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NENTRY - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDXW'(i);
      end
    end
  end

`ifdef UTLB_HUGE_PAGE_EN
  assign w_hit_huge = r_huge[w_hit_idx];
`else
  assign w_hit_huge = 1'b0;
`endif

  // ------------------------------------------------- locally resolved result
  logic        w_da;
  logic        w_dmw0_hit;
  logic        w_dmw1_hit;
  logic        w_local;
  logic [31:0] w_loc_paddr;
  logic [1:0]  w_loc_mat;
  logic [2:0]  w_loc_exc;

  assign w_da       = bus.csr_da && !bus.csr_pg;
  assign w_dmw0_hit = dmw_hit(bus.csr_dmw0, bus.req_vaddr, bus.csr_plv);
  assign w_dmw1_hit = dmw_hit(bus.csr_dmw1, bus.req_vaddr, bus.csr_plv);
  assign w_local    = w_da || w_dmw0_hit || w_dmw1_hit || w_hit;

  always_comb begin
    w_loc_paddr = bus.req_vaddr;
    w_loc_mat   = bus.csr_datm;
    w_loc_exc   = EXC_NONE;
    if (w_da) begin
      w_loc_paddr = bus.req_vaddr;
      w_loc_mat   = bus.csr_datm;
    end else if (w_dmw0_hit) begin
      w_loc_paddr = {bus.csr_dmw0[27:25], bus.req_vaddr[28:0]};
      w_loc_mat   = bus.csr_dmw0[5:4];
    end else if (w_dmw1_hit) begin
      w_loc_paddr = {bus.csr_dmw1[27:25], bus.req_vaddr[28:0]};
      w_loc_mat   = bus.csr_dmw1[5:4];
    end else begin
      w_loc_paddr = w_hit_huge ? {r_ppn[w_hit_idx][19:9], bus.req_vaddr[20:0]}
                               : {r_ppn[w_hit_idx], bus.req_vaddr[11:0]};
      w_loc_mat   = r_mat[w_hit_idx];
      w_loc_exc   = perm_exc(bus.csr_plv, r_plv[w_hit_idx], bus.req_store, r_d[w_hit_idx]);
    end
  end

  // ------------------------------------------------------- refill result
  logic        w_rf_huge;
  logic [31:0] w_rf_paddr;
  logic [2:0]  w_rf_exc;
  logic        w_rf_done;
  logic        w_install;

  assign w_rf_huge  = (bus.rf_resp_ps == 6'd21);
  assign w_rf_paddr = w_rf_huge ? {bus.rf_resp_ppn[19:9], r_vaddr[20:0]}
                                : {bus.rf_resp_ppn, r_vaddr[11:0]};
  assign w_rf_exc   = !bus.rf_resp_found ? EXC_TLBR :
                      !bus.rf_resp_v     ? EXC_PI   :
                      perm_exc(bus.csr_plv, bus.rf_resp_plv, r_store, bus.rf_resp_d);
  assign w_rf_done  = (r_state == S_RF_WAIT) && bus.rf_resp_valid;

  // A flush in the completion cycle itself also blocks the install: the
  // flush clears the valid bits on the same edge and must win.
  assign w_install  = w_rf_done && bus.rf_resp_found && bus.rf_resp_v && !r_noinst &&
                      !bus.flush && ((bus.rf_resp_ps == 6'd12) || HUGE_EN);

  // Victim: lowest invalid entry, else the round-robin pointer.
  logic            w_has_free;
  logic [IDXW-1:0] w_free_idx;
  logic [IDXW-1:0] w_victim;

  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = NENTRY - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDXW'(i);
      end
    end
  end

  assign w_victim = w_has_free ? w_free_idx : r_rr;

  // ------------------------------------------------------------------ FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_resp_valid   <= 1'b0;
      r_resp_paddr   <= '0;
      r_resp_mat     <= '0;
      r_resp_exc     <= EXC_NONE;
      r_rf_req_valid <= 1'b0;
      r_rf_req_vpn   <= '0;
      r_vaddr        <= '0;
      r_store        <= 1'b0;
      r_noinst       <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            if (w_local) begin
              r_resp_valid <= 1'b1;
              r_resp_paddr <= w_loc_paddr;
              r_resp_mat   <= w_loc_mat;
              r_resp_exc   <= w_loc_exc;
              r_state      <= S_RESP;
            end else begin
              r_vaddr        <= bus.req_vaddr;
              r_store        <= bus.req_store;
              r_rf_req_valid <= 1'b1;
              r_rf_req_vpn   <= w_req_vpn;
              r_noinst       <= 1'b0;
              r_state        <= S_RF_REQ;
            end
          end
        end
        S_RF_REQ: begin
          if (bus.flush) r_noinst <= 1'b1;
          if (bus.rf_req_ready) begin
            r_rf_req_valid <= 1'b0;
            r_state        <= S_RF_WAIT;
          end
        end
        S_RF_WAIT: begin
          if (bus.flush) r_noinst <= 1'b1;
          if (bus.rf_resp_valid) begin
            r_resp_valid <= 1'b1;
            r_resp_paddr <= w_rf_paddr;
            r_resp_mat   <= bus.rf_resp_mat;
            r_resp_exc   <= w_rf_exc;
            r_state      <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- uTLB contents
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
      r_rr    <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
    end else if (w_install) begin
      r_valid[w_victim] <= 1'b1;
      if (!w_has_free) r_rr <= r_rr + 1'b1;   // power-of-two size: wraps to 0
    end
  end

  // NOTE: entry payload has no reset; it is never observed while the
  // matching valid bit is clear, and only the valid bits need a known value.
  always_ff @(posedge clk) begin
    if (w_install) begin
      r_vpn[w_victim]  <= r_vaddr[31:12];
      r_asid[w_victim] <= bus.csr_asid;
      r_g[w_victim]    <= bus.rf_resp_g;
      r_ppn[w_victim]  <= bus.rf_resp_ppn;
      r_d[w_victim]    <= bus.rf_resp_d;
      r_mat[w_victim]  <= bus.rf_resp_mat;
      r_plv[w_victim]  <= bus.rf_resp_plv;
`ifdef UTLB_HUGE_PAGE_EN
      r_huge[w_victim] <= w_rf_huge;
`endif
    end
  end

  // --------------------------------------------------------------- outputs
  assign bus.req_ready    = (r_state == S_IDLE) && !bus.flush;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_paddr   = r_resp_paddr;
  assign bus.resp_mat     = r_resp_mat;
  assign bus.resp_exc     = r_resp_exc;
  assign bus.rf_req_valid = r_rf_req_valid;
  assign bus.rf_req_vpn   = r_rf_req_vpn;

endmodule

// File: tb/tb_utlb_trans.sv
// ---------------------------------------------------------------------------
// tb_utlb_trans
//   Directed bench for utlb_trans (NENTRY=4). The bench plays the pipeline
//   stage and the shared TLB. Inputs are driven and outputs sampled on the
//   falling clock edge. Expected values are hand-computed constants.
//   Build with +define+UTLB_HUGE_PAGE_EN to exercise the huge-page option.
// ---------------------------------------------------------------------------
module tb_utlb_trans;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  utlb_trans_if u_if ();

  utlb_trans #(.NENTRY(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (u_if)
  );

  int checks = 0;
  int errors = 0;

  // Shared-TLB answer the bench gives when the DUT asks for a refill.
  typedef struct {
    logic        found, v, d, g;
    logic [5:0]  ps;
    logic [19:0] ppn;
    logic [1:0]  mat, plv;
    logic        flush_wait;   // pulse flush during RF_WAIT
  } rf_t;

  // Observed outcome of one access.
  typedef struct packed {
    logic        to;      // a bounded wait expired
    logic        miss;    // a refill request was seen
    logic        fast;    // response in the cycle after acceptance
    logic        pulse;   // resp_valid dropped the cycle after
    logic [19:0] vpn;     // refill vpn (0 when no refill)
    logic [31:0] pa;
    logic [1:0]  mat;
    logic [2:0]  exc;
  } res_t;

  function automatic rf_t mk_rf(input logic found, input logic v, input logic d,
                                input logic [1:0] plv, input logic [1:0] mat,
                                input logic [19:0] ppn, input logic [5:0] ps,
                                input logic flush_wait);
    rf_t r;
    r.found = found; r.v = v; r.d = d; r.g = 1'b0; r.ps = ps; r.ppn = ppn;
    r.mat = mat; r.plv = plv; r.flush_wait = flush_wait;
    return r;
  endfunction

  function automatic res_t exp_res(input logic miss, input logic [19:0] vpn,
                                   input logic [31:0] pa, input logic [1:0] mat,
                                   input logic [2:0] exc);
    res_t e;
    e.to = 1'b0; e.miss = miss; e.fast = !miss; e.pulse = 1'b1;
    e.vpn = vpn; e.pa = pa; e.mat = mat; e.exc = exc;
    return e;
  endfunction

  // Drive one request, serve a refill if asked, capture the response.
  task automatic access(input logic [31:0] va, input logic st, input rf_t rf, output res_t r);
    int n;
    r = '0;
    @(negedge clk);
    u_if.req_valid = 1'b1;
    u_if.req_vaddr = va;
    u_if.req_store = st;
    n = 0;
    while (!u_if.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!u_if.req_ready) r.to = 1'b1;
    @(negedge clk);
    u_if.req_valid = 1'b0;
    n = 0;
    while (!u_if.resp_valid && n < 40) begin
      if (u_if.rf_req_valid && !r.miss) begin
        r.miss = 1'b1;
        r.vpn  = u_if.rf_req_vpn;
        @(negedge clk);                        // one cycle of back-pressure
        if (u_if.rf_req_vpn !== r.vpn || !u_if.rf_req_valid) r.vpn = ~r.vpn;
        u_if.rf_req_ready = 1'b1;
        @(negedge clk);
        u_if.rf_req_ready = 1'b0;
        u_if.flush        = rf.flush_wait;
        @(negedge clk);
        u_if.flush         = 1'b0;
        u_if.rf_resp_valid = 1'b1;
        u_if.rf_resp_found = rf.found;
        u_if.rf_resp_v     = rf.v;
        u_if.rf_resp_d     = rf.d;
        u_if.rf_resp_g     = rf.g;
        u_if.rf_resp_ps    = rf.ps;
        u_if.rf_resp_ppn   = rf.ppn;
        u_if.rf_resp_mat   = rf.mat;
        u_if.rf_resp_plv   = rf.plv;
        @(negedge clk);
        u_if.rf_resp_valid = 1'b0;
        n += 4;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!u_if.resp_valid) begin
      r.to = 1'b1;
    end else begin
      r.fast = (n == 0);
      r.pa   = u_if.resp_paddr;
      r.mat  = u_if.resp_mat;
      r.exc  = u_if.resp_exc;
      @(negedge clk);
      r.pulse = !u_if.resp_valid;
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    u_if.flush = 1'b1;
    @(negedge clk);
    u_if.flush = 1'b0;
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({u_if.req_ready, u_if.resp_valid, u_if.resp_paddr, u_if.resp_mat, u_if.resp_exc,
         u_if.rf_req_valid, u_if.rf_req_vpn} !== {1'b1, 1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 20'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rv=%b pa=%h mat=%0d exc=%0d rfv=%b vpn=%h, want 1 0 0 0 0 0 0",
               u_if.req_ready, u_if.resp_valid, u_if.resp_paddr, u_if.resp_mat, u_if.resp_exc,
               u_if.rf_req_valid, u_if.rf_req_vpn);
    end
  endtask

  task automatic test_da();
    res_t r, e;
    rf_t  rf = mk_rf(1, 1, 1, 0, 0, 20'h0, 6'd12, 0);
    u_if.csr_da = 1'b1; u_if.csr_pg = 1'b0; u_if.csr_datm = 2'd1;
    access(32'h1C00_0104, 1'b0, rf, r);
    e = exp_res(0, 20'h0, 32'h1C00_0104, 2'd1, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL da_mode: got %p want %p", r, e); end
    u_if.csr_da = 1'b0; u_if.csr_pg = 1'b1;
  endtask

  task automatic test_dmw();
    res_t r, e;
    rf_t  rf = mk_rf(1, 1, 1, 2'd3, 2'd2, 20'hABCDE, 6'd12, 0);
    u_if.csr_plv = 2'd0; u_if.csr_dmw0 = 32'h8000_0011; u_if.csr_dmw1 = 32'h0;
    access(32'h8000_1234, 1'b0, rf, r);
    e = exp_res(0, 20'h0, 32'h0000_1234, 2'd1, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL dmw0_hit: got %p want %p", r, e); end

    u_if.csr_dmw1 = 32'h8200_0021;             // same VSEG: DMW0 keeps priority
    access(32'h8000_1234, 1'b0, rf, r);
    checks++;
    if (r !== e) begin errors++; $display("FAIL dmw_priority: got %p want %p", r, e); end

    u_if.csr_dmw0 = 32'h0;
    access(32'h8000_1234, 1'b0, rf, r);
    e = exp_res(0, 20'h0, 32'h2000_1234, 2'd2, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL dmw1_hit: got %p want %p", r, e); end

    u_if.csr_dmw0 = 32'h8000_0011; u_if.csr_dmw1 = 32'h0; u_if.csr_plv = 2'd3;
    access(32'h8000_1234, 1'b0, rf, r);
    e = exp_res(1, 20'h80001, 32'hABCD_E234, 2'd2, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL dmw_plv3_refill: got %p want %p", r, e); end
    u_if.csr_plv = 2'd0; u_if.csr_dmw0 = 32'h0;
  endtask

  task automatic test_miss_hit();
    res_t r, e;
    rf_t  rf = mk_rf(1, 1, 1, 2'd0, 2'd1, 20'h12345, 6'd12, 0);
    pulse_flush();
    access(32'h0040_2008, 1'b0, rf, r);
    e = exp_res(1, 20'h00402, 32'h1234_5008, 2'd1, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL miss_refill: got %p want %p", r, e); end

    access(32'h0040_2008, 1'b0, rf, r);
    e = exp_res(0, 20'h0, 32'h1234_5008, 2'd1, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL repeat_hit: got %p want %p", r, e); end

    u_if.csr_asid = 10'h006;                    // non-global entry, other ASID
    access(32'h0040_2008, 1'b0, rf, r);
    e = exp_res(1, 20'h00402, 32'h1234_5008, 2'd1, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL asid_mismatch_miss: got %p want %p", r, e); end
    u_if.csr_asid = 10'h005;

    @(negedge clk);
    u_if.flush = 1'b1;
    #1;
    checks++;
    if (u_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_during_flush: got %b want 0", u_if.req_ready);
    end
    @(negedge clk);
    u_if.flush = 1'b0;
    access(32'h0040_2008, 1'b0, rf, r);
    e = exp_res(1, 20'h00402, 32'h1234_5008, 2'd1, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL miss_after_flush: got %p want %p", r, e); end
  endtask

  task automatic test_faults();
    res_t r, e;
    pulse_flush();
    access(32'h0050_0000, 1'b0, mk_rf(0, 0, 0, 2'd0, 2'd0, 20'h0, 6'd12, 0), r);
    checks++;
    if ({r.to, r.miss, r.exc} !== {1'b0, 1'b1, 3'd1}) begin
      errors++; $display("FAIL tlbr: got to=%b miss=%b exc=%0d want 0 1 1", r.to, r.miss, r.exc);
    end

    for (int k = 0; k < 2; k++) begin           // invalid page is never installed
      access(32'h0060_0000, 1'b0, mk_rf(1, 0, 1, 2'd0, 2'd0, 20'h0, 6'd12, 0), r);
      checks++;
      if ({r.to, r.miss, r.exc} !== {1'b0, 1'b1, 3'd2}) begin
        errors++; $display("FAIL pi_%0d: got to=%b miss=%b exc=%0d want 0 1 2", k, r.to, r.miss, r.exc);
      end
    end

    access(32'h0070_0010, 1'b1, mk_rf(1, 1, 0, 2'd0, 2'd0, 20'h33333, 6'd12, 0), r);
    e = exp_res(1, 20'h00700, 32'h3333_3010, 2'd0, 3'd4);
    checks++;
    if (r !== e) begin errors++; $display("FAIL pme_refill: got %p want %p", r, e); end
    access(32'h0070_0010, 1'b1, mk_rf(1, 1, 0, 2'd0, 2'd0, 20'h33333, 6'd12, 0), r);
    e = exp_res(0, 20'h0, 32'h3333_3010, 2'd0, 3'd4);
    checks++;
    if (r !== e) begin errors++; $display("FAIL pme_hit: got %p want %p", r, e); end
    access(32'h0070_0010, 1'b0, mk_rf(1, 1, 0, 2'd0, 2'd0, 20'h33333, 6'd12, 0), r);
    e = exp_res(0, 20'h0, 32'h3333_3010, 2'd0, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL load_clean_hit: got %p want %p", r, e); end

    u_if.csr_plv = 2'd3;
    access(32'h0080_0000, 1'b0, mk_rf(1, 1, 1, 2'd0, 2'd1, 20'h44444, 6'd12, 0), r);
    e = exp_res(1, 20'h00800, 32'h4444_4000, 2'd1, 3'd3);
    checks++;
    if (r !== e) begin errors++; $display("FAIL ppi_refill: got %p want %p", r, e); end
    access(32'h0080_0000, 1'b0, mk_rf(1, 1, 1, 2'd0, 2'd1, 20'h44444, 6'd12, 0), r);
    e = exp_res(0, 20'h0, 32'h4444_4000, 2'd1, 3'd3);
    checks++;
    if (r !== e) begin errors++; $display("FAIL ppi_hit: got %p want %p", r, e); end
    u_if.csr_plv = 2'd0;
  endtask

  task automatic test_replacement();
    res_t r, e;
    logic [31:0] va;
    logic [19:0] ppn;
    pulse_flush();
    for (int i = 0; i < 5; i++) begin           // P0..P3 fill, P4 evicts entry 0
      va  = 32'h0100_0000 + (i << 12);
      ppn = 20'h20000 + 20'(i);
      access(va, 1'b0, mk_rf(1, 1, 1, 2'd0, 2'd1, ppn, 6'd12, 0), r);
      e = exp_res(1, va[31:12], {ppn, 12'h000}, 2'd1, 3'd0);
      checks++;
      if (r !== e) begin errors++; $display("FAIL fill_p%0d: got %p want %p", i, r, e); end
    end
    for (int i = 1; i < 5; i++) begin
      va  = 32'h0100_0000 + (i << 12);
      ppn = 20'h20000 + 20'(i);
      access(va, 1'b0, mk_rf(1, 1, 1, 2'd0, 2'd1, ppn, 6'd12, 0), r);
      e = exp_res(0, 20'h0, {ppn, 12'h000}, 2'd1, 3'd0);
      checks++;
      if (r !== e) begin errors++; $display("FAIL resident_p%0d: got %p want %p", i, r, e); end
    end
    // P0 was evicted; its refill goes to entry 1 (pointer now 1), evicting P1.
    access(32'h0100_0000, 1'b0, mk_rf(1, 1, 1, 2'd0, 2'd1, 20'h20000, 6'd12, 0), r);
    e = exp_res(1, 20'h01000, 32'h2000_0000, 2'd1, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL evicted_p0: got %p want %p", r, e); end
    // P1 now misses; flush during RF_WAIT: result returned but not installed.
    access(32'h0100_1000, 1'b0, mk_rf(1, 1, 1, 2'd0, 2'd1, 20'h20001, 6'd12, 1), r);
    e = exp_res(1, 20'h01001, 32'h2000_1000, 2'd1, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL rr_victim_p1: got %p want %p", r, e); end
    access(32'h0100_1000, 1'b0, mk_rf(1, 1, 1, 2'd0, 2'd1, 20'h20001, 6'd12, 0), r);
    checks++;
    if (r !== e) begin errors++; $display("FAIL no_install_after_flush: got %p want %p", r, e); end
  endtask

  task automatic test_huge();
    res_t r, e;
    rf_t  rf = mk_rf(1, 1, 1, 2'd0, 2'd1, 20'h00600, 6'd21, 0);
    pulse_flush();
    access(32'h0020_0000, 1'b0, rf, r);
    e = exp_res(1, 20'h00200, 32'h0060_0000, 2'd1, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL huge_refill: got %p want %p", r, e); end
    access(32'h003F_F000, 1'b0, rf, r);
`ifdef UTLB_HUGE_PAGE_EN
    e = exp_res(0, 20'h0, 32'h007F_F000, 2'd1, 3'd0);
`else
    e = exp_res(1, 20'h003FF, 32'h007F_F000, 2'd1, 3'd0);
`endif
    checks++;
    if (r !== e) begin errors++; $display("FAIL huge_other_4k: got %p want %p", r, e); end
    access(32'h0020_0000, 1'b0, rf, r);
`ifdef UTLB_HUGE_PAGE_EN
    e = exp_res(0, 20'h0, 32'h0060_0000, 2'd1, 3'd0);
`else
    e = exp_res(1, 20'h00200, 32'h0060_0000, 2'd1, 3'd0);
`endif
    checks++;
    if (r !== e) begin errors++; $display("FAIL huge_repeat: got %p want %p", r, e); end
  endtask

  task automatic test_reset_mid_refill();
    res_t r, e;
    @(negedge clk);
    u_if.req_valid = 1'b1; u_if.req_vaddr = 32'h0090_0000; u_if.req_store = 1'b0;
    @(negedge clk);
    u_if.req_valid    = 1'b0;
    u_if.rf_req_ready = 1'b1;
    @(negedge clk);
    u_if.rf_req_ready = 1'b0;                   // DUT now waits for the result
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checks++;
    if ({u_if.req_ready, u_if.rf_req_valid, u_if.resp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_refill: got ready=%b rfv=%b rv=%b want 1 0 0",
               u_if.req_ready, u_if.rf_req_valid, u_if.resp_valid);
    end
    u_if.rf_resp_valid = 1'b1; u_if.rf_resp_found = 1'b1; u_if.rf_resp_v = 1'b1;
    @(negedge clk);
    u_if.rf_resp_valid = 1'b0;
    checks++;
    if (u_if.resp_valid !== 1'b0) begin
      errors++; $display("FAIL late_rf_resp_ignored: got resp_valid=%b want 0", u_if.resp_valid);
    end
    access(32'h0020_0000, 1'b0, mk_rf(1, 1, 1, 2'd0, 2'd1, 20'h00600, 6'd21, 0), r);
    e = exp_res(1, 20'h00200, 32'h0060_0000, 2'd1, 3'd0);
    checks++;
    if (r !== e) begin errors++; $display("FAIL entries_cleared_by_reset: got %p want %p", r, e); end
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    resetn = 1'b0;
    u_if.req_valid = 1'b0; u_if.req_vaddr = '0; u_if.req_store = 1'b0;
    u_if.csr_da = 1'b0; u_if.csr_pg = 1'b1; u_if.csr_datm = 2'd0; u_if.csr_plv = 2'd0;
    u_if.csr_asid = 10'h005; u_if.csr_dmw0 = '0; u_if.csr_dmw1 = '0; u_if.flush = 1'b0;
    u_if.rf_req_ready = 1'b0; u_if.rf_resp_valid = 1'b0; u_if.rf_resp_found = 1'b0;
    u_if.rf_resp_v = 1'b0; u_if.rf_resp_d = 1'b0; u_if.rf_resp_g = 1'b0;
    u_if.rf_resp_ps = 6'd12; u_if.rf_resp_ppn = '0; u_if.rf_resp_mat = '0; u_if.rf_resp_plv = '0;

    test_reset();
    test_da();
    test_dmw();
    test_miss_hit();
    test_faults();
    test_replacement();
    test_huge();
    test_reset_mid_refill();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
